ifetch_queue: RTL

- Instruction fetch stage that sits directly upstream of the CPU decode/execute datapath.
- Owns the fetch PC and issues requests to the instruction memory over a req/ack handshake with variable latency.
- Buffers returned 12-bit instructions, tagged with their PC, in a small first-word-fall-through queue.
- Presents them to decode over a valid/ready handshake and supports branch redirect with flush.

---
 rtl/ifetch_queue.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
//
// Instruction fetch stage in front of decode. It owns the fetch PC and issues
// one request at a time to instruction memory over a req/ack handshake with
// variable latency. Returned instructions are tagged with their PC and kept in
// a small first-word-fall-through queue that decode drains over valid/ready.
// A redirect flushes the queue and restarts fetch at redirect_pc. A request
// that is still outstanding when a redirect arrives is drained: its ack is
// awaited and the data dropped.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   imem_req      fetch request, held high until imem_ack
//   imem_addr     fetch address, stable while imem_req is high
//   imem_ack      memory returns imem_rdata this cycle
//   imem_rdata    fetched instruction
//   redirect      flush queue and restart fetch at redirect_pc
//   redirect_pc   redirect target
//   instr_valid   queue head valid
//   instr_ready   decode accepts the head this cycle
//   instr         queue head instruction
//   instr_pc      PC of the queue head
//   fetch_pc      next address to fetch
//   stall_cnt     (IFQ_STATS_EN only) saturating count of cycles without a
//                 valid head; cleared by rst and redirect
//
// Build option: define IFQ_STATS_EN to add the stall_cnt output.
// ----------------------------------------------------------------------------
module ifetch_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
`ifdef IFQ_STATS_EN
    output logic [15:0]        stall_cnt,
`endif
    output logic [ADDR_W-1:0]  fetch_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [INSTR_W-1:0]  mem_instr_q [DEPTH];
    logic [INSTR_W-1:0]  mem_instr_d [DEPTH];
    logic [ADDR_W-1:0]   mem_pc_q    [DEPTH];
    logic [ADDR_W-1:0]   mem_pc_d    [DEPTH];
    logic                push_s;
    logic                pop_s;

    // Request / queue outputs decoded from registered state
    assign imem_req    = (state_q == WAIT) || (state_q == DRAIN);
    // req_addr_q equals fetch_pc_q throughout WAIT and holds the old address in DRAIN
    assign imem_addr   = imem_req ? req_addr_q : {ADDR_W{1'b0}};
    assign instr_valid = (count_q != {CNT_W{1'b0}});
    assign instr       = mem_instr_q[rd_ptr_q];
    assign instr_pc    = mem_pc_q[rd_ptr_q];
    assign fetch_pc    = fetch_pc_q;

    // Fetch FSM next-state, fetch PC and push decision
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        push_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (count_q < DEPTH_C) begin
                    state_d    = WAIT;
                    req_addr_d = fetch_pc_q;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    // an unanswered request must still be drained
                    state_d    = imem_ack ? IDLE : DRAIN;
                end else if (imem_ack) begin
                    push_s     = 1'b1;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1'b1);
                    state_d    = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                // the ack closes the stale request even if a redirect arrives with it
                if (imem_ack) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Queue pointers, occupancy and storage write; redirect flush wins over push/pop
    always_comb begin
        pop_s       = instr_valid && instr_ready && !redirect;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        mem_instr_d = mem_instr_q;
        mem_pc_d    = mem_pc_q;
        if (redirect) begin
            count_d  = {CNT_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_instr_d[wr_ptr_q] = imem_rdata;
                mem_pc_d[wr_ptr_q]    = req_addr_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1'b1);
                2'b01:   count_d = count_q - CNT_W'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // State, PC and queue registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= {ADDR_W{1'b0}};
            req_addr_q <= {ADDR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= {INSTR_W{1'b0}};
                mem_pc_q[i]    <= {ADDR_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_addr_q  <= req_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_instr_q <= mem_instr_d;
            mem_pc_q    <= mem_pc_d;
        end
    end

`ifdef IFQ_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt = stall_cnt_q;

    // Saturating count of cycles with no valid head; redirect clears it
    always_comb begin
        if (redirect) begin
            stall_cnt_d = 16'h0000;
        end else if (!instr_valid && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule
